// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on operand magnitudes; sign fix-up in a final cycle.
//
// state  | meaning
// S_IDLE | waiting for start; MTHI/MTLO writes accepted
// S_CALC | one shift-add / shift-subtract iteration per clock, WIDTH iterations
// S_FIX  | sign correction and HI/LO write-back
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_div_zero;
   logic [WIDTH-1:0]       r_hi;
   logic [WIDTH-1:0]       r_lo;
   logic                   r_is_div;
   logic                   r_neg_a;
   logic                   r_neg_res;
   logic [WIDTH-1:0]       r_ma;
   logic [WIDTH-1:0]       r_mb;
   logic [2*WIDTH-1:0]     r_acc;
   logic [CNT_W-1:0]       r_cnt;

   logic                   w_accept;
   logic                   w_calc_last;
   logic                   w_fix_write;
   logic                   w_neg_a;
   logic                   w_neg_b;
   logic [WIDTH-1:0]       w_mag_a;
   logic [WIDTH-1:0]       w_mag_b;
   logic [WIDTH:0]         w_mul_sum;
   logic [2*WIDTH-1:0]     w_mul_next;
   logic [WIDTH:0]         w_div_rs;
   logic [WIDTH:0]         w_div_diff;
   logic [2*WIDTH-1:0]     w_div_next;
   logic [2*WIDTH-1:0]     w_prod;
   logic [WIDTH-1:0]       w_quo_fix;
   logic [WIDTH-1:0]       w_rem_fix;

   assign w_accept    = (r_state == S_IDLE) && start && !flush;
   assign w_calc_last = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_fix_write = (r_state == S_FIX) && !flush;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_CALC;
         S_CALC: begin
            if (flush)            w_next = S_IDLE;
            else if (w_calc_last) w_next = S_FIX;
         end
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != S_IDLE);
         r_done  <= w_fix_write;
      end
   end

   // Operand magnitudes: only the signed ops (op[0]=1) take absolute values.
   assign w_neg_a = op[0] & a[WIDTH-1];
   assign w_neg_b = op[0] & b[WIDTH-1];
   assign w_mag_a = w_neg_a ? -a : a;
   assign w_mag_b = w_neg_b ? -b : b;

   // Multiply: r_acc = {partial product, remaining multiplier bits}.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mb} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide: r_acc = {remainder, dividend bits shifting into quotient bits}.
   assign w_div_rs   = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_div_diff = w_div_rs - {1'b0, r_mb};
   assign w_div_next = w_div_diff[WIDTH] ?
                       {w_div_rs[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b0} :
                       {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_prod    = r_neg_res ? -r_acc : r_acc;
   assign w_quo_fix = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem_fix = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_div  <= 1'b0;
         r_neg_a   <= 1'b0;
         r_neg_res <= 1'b0;
         r_ma      <= '0;
         r_mb      <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
      end else if (w_accept) begin
         r_is_div  <= op[1];
         r_neg_a   <= w_neg_a;
         r_neg_res <= w_neg_a ^ w_neg_b;
         r_ma      <= w_mag_a;
         r_mb      <= w_mag_b;
         r_acc     <= {{WIDTH{1'b0}}, w_mag_a};
         r_cnt     <= '0;
      end else if (r_state == S_CALC) begin
         r_cnt <= r_cnt + CNT_W'(1);
         r_acc <= r_is_div ? w_div_next : w_mul_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi       <= '0;
         r_lo       <= '0;
         r_div_zero <= 1'b0;
      end else if (w_fix_write) begin
         if (!r_is_div) begin
            {r_hi, r_lo} <= w_prod;
         end else if (r_mb == '0) begin
            // Divide by zero: no trap, HI carries the raw dividend magnitude.
            r_lo       <= '1;
            r_hi       <= r_ma;
            r_div_zero <= 1'b1;
         end else begin
            r_lo       <= w_quo_fix;
            r_hi       <= w_rem_fix;
            r_div_zero <= 1'b0;
         end
      end else if ((r_state == S_IDLE) && !w_accept) begin
         if (hi_we) r_hi <= wdata;
         if (lo_we) r_lo <= wdata;
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed cases plus randomized ops against
// a 64-bit arithmetic reference model; a monitor checks every done pulse.
module tb_muldiv_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = 2'b00;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          flush = 1'b0;
   logic          hi_we = 1'b0;
   logic          lo_we = 1'b0;
   logic [W-1:0]  wdata = '0;
   logic          busy;
   logic          done;
   logic          div_zero;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
      .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;
   logic         m_dz = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
   endtask

   // Reference model: plain 64-bit arithmetic, SV '/' and '%' truncate toward zero.
   task automatic push_expected(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input int exp_cyc);
      longint unsigned ux = x;
      longint unsigned uy = y;
      longint          sx = $signed(x);
      longint          sy = $signed(y);
      logic [63:0]     p;
      exp_t            e;
      case (o)
         2'b00: begin p = ux * uy; m_hi = p[63:32]; m_lo = p[31:0]; end
         2'b01: begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
         2'b10: begin
            if (y == 0) begin m_lo = '1; m_hi = x; m_dz = 1'b1; end
            else begin p = ux / uy; m_lo = p[31:0]; p = ux % uy; m_hi = p[31:0]; m_dz = 1'b0; end
         end
         default: begin
            if (y == 0) begin
               p = (sx < 0) ? -sx : sx;
               m_lo = '1; m_hi = p[31:0]; m_dz = 1'b1;
            end else begin
               p = sx / sy; m_lo = p[31:0]; p = sx % sy; m_hi = p[31:0]; m_dz = 1'b0;
            end
         end
      endcase
      e.hi = m_hi; e.lo = m_lo; e.dz = m_dz; e.cyc = exp_cyc;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && done) begin
         check("busy_low_in_done", {63'd0, busy}, 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("hi", {32'd0, hi}, {32'd0, e.hi});
            check("lo", {32'd0, lo}, {32'd0, e.lo});
            check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
            check("done_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Caller is at a negedge; start is sampled at the following posedge (E0),
   // and done is seen at the negedge after edge E0+W+1.
   task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1; op = o; a = x; b = y;
      push_expected(o, x, y, cyc + W + 2);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) return;
      end
      timeout("wait_done");
   endtask

   task automatic wait_idle;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) return;
      end
      timeout("wait_idle");
   endtask

   task automatic mt_write(input logic hw, input logic lw, input logic [W-1:0] d);
      hi_we = hw; lo_we = lw; wdata = d;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      if (hw) m_hi = d;
      if (lw) m_lo = d;
      check("mt_hi", {32'd0, hi}, {32'd0, m_hi});
      check("mt_lo", {32'd0, lo}, {32'd0, m_lo});
   endtask

   task automatic quiet_window(input string name, input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
      check({name, "_hi_kept"}, {32'd0, hi}, {32'd0, m_hi});
      check({name, "_lo_kept"}, {32'd0, lo}, {32'd0, m_lo});
      check({name, "_dz_kept"}, {63'd0, div_zero}, {63'd0, m_dz});
   endtask

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'd1;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      repeat (2) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_dz", {63'd0, div_zero}, 64'd0);
      check("rst_hi", {32'd0, hi}, 64'd0);
      check("rst_lo", {32'd0, lo}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // MULTU max*max with busy-duration count
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      bc = 0;
      for (int i = 0; i < 100; i++) begin
         if (done) break;
         if (busy) bc++;
         @(negedge clk);
      end
      check("busy_cycles", 64'(bc), 64'(W + 1));
      check("multu_max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
      check("multu_max_lo", {32'd0, lo}, 64'h0000_0001);
      wait_idle();

      // MULT -7*6, then DIV -7/2 issued in the done cycle
      issue(2'b01, 32'hFFFF_FFF9, 32'd6);
      wait_done();
      check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFD6);
      issue(2'b11, 32'hFFFF_FFF9, 32'd2);
      wait_idle();
      check("div_neg_lo", {32'd0, lo}, 64'hFFFF_FFFD);
      check("div_neg_hi", {32'd0, hi}, 64'hFFFF_FFFF);

      // Divide by zero then a normal divide clearing the flag
      issue(2'b10, 32'd100, 32'd0);
      wait_idle();
      check("divz_flag", {63'd0, div_zero}, 64'd1);
      issue(2'b10, 32'd100, 32'd7);
      wait_idle();
      check("divu_lo", {32'd0, lo}, 64'd14);
      check("divu_hi", {32'd0, hi}, 64'd2);

      // Signed overflow wrap
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();
      check("div_ovf_lo", {32'd0, lo}, 64'h8000_0000);
      check("div_ovf_hi", {32'd0, hi}, 64'd0);

      // Flush mid-CALC; mid-op start and hi_we must be ignored
      start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; op = 2'b10; a = 32'd9; b = 32'd3; hi_we = 1'b1; wdata = 32'hDEAD;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", {63'd0, busy}, 64'd0);
      quiet_window("flush_calc", 40);

      // Flush in the FIX cycle beats the write-back (divide by zero must not set the flag)
      start = 1'b1; op = 2'b10; a = 32'd55; b = 32'd0;
      @(negedge clk);
      start = 1'b0;
      repeat (W) @(negedge clk);
      check("fix_still_busy", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_fix_done", {63'd0, done}, 64'd0);
      check("flush_fix_busy", {63'd0, busy}, 64'd0);
      quiet_window("flush_fix", 10);

      // Start together with flush in IDLE is ignored
      start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd2; b = 32'd2;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", {63'd0, busy}, 64'd0);
      quiet_window("flush_start", 40);

      // MTHI/MTLO
      mt_write(1'b1, 1'b1, 32'h1234);
      mt_write(1'b1, 1'b0, 32'hABCD);
      mt_write(1'b0, 1'b1, 32'h5A5A);

      // Randomized ops, mixing back-to-back issue and MT writes
      for (int k = 0; k < 40; k++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ro = 2'($urandom_range(0, 3));
         ra = pick_val();
         rb = pick_val();
         issue(ro, ra, rb);
         if ($urandom_range(0, 1) == 1) begin
            wait_done();
         end else begin
            wait_idle();
            if ($urandom_range(0, 3) == 0)
               mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         end
      end
      wait_idle();

      // Async reset mid-CALC after setting up non-zero state
      issue(2'b10, 32'd77, 32'd0);
      wait_idle();
      start = 1'b1; op = 2'b01; a = 32'd123; b = 32'd456;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", {63'd0, busy}, 64'd0);
      check("async_rst_done", {63'd0, done}, 64'd0);
      check("async_rst_dz", {63'd0, div_zero}, 64'd0);
      check("async_rst_hi", {32'd0, hi}, 64'd0);
      check("async_rst_lo", {32'd0, lo}, 64'd0);
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(2'b11, 32'd200, 32'hFFFF_FFFD);
      wait_idle();
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
